// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4:1 mux. It steps the select lines through the enabled channels,
// holds each select for SETTLE_CYCLES, samples the mux output and returns a 4-bit result
// over a valid/ready handshake.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       mux_out,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [3:0] result,
  output logic       result_valid,
  input  logic       result_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       result_q, result_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       higher_en;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Enabled channels strictly above the one currently selected.
  assign higher_en = mask_q & (4'b1110 << sel_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    result_d = result_q;
    sel_d    = sel_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_d   = mask;
          result_d = 4'b0000;
          cnt_d    = '0;
          if (mask != 4'b0000) begin
            sel_d   = lowest_set(mask);
            state_d = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          result_d[sel_q] = mux_out;
          cnt_d           = '0;
          if (higher_en != 4'b0000) begin
            sel_d = lowest_set(higher_en);
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (result_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= 4'b0000;
      result_q <= 4'b0000;
      sel_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      sel_q    <= sel_d;
    end
  end

  assign s1           = sel_q[1];
  assign s0           = sel_q[0];
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: a behavioural 4:1 mux, with outputs sampled 1ns after each rising edge.
module tb_mux_scan_sequencer;

  logic       clock = 1'b0;
  logic       reset, start, result_ready;
  logic [3:0] mask;
  logic [3:0] mux_in;
  logic       mux_out;
  logic       s1, s0, busy, result_valid;
  logic [3:0] result;

  int n_vec = 0;
  int n_bad = 0;

  mux_scan_sequencer #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .mask         (mask),
    .mux_out      (mux_out),
    .s1           (s1),
    .s0           (s0),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clock = ~clock;

  assign mux_out = mux_in[{s1, s0}];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic b, input logic v,
                         input logic [1:0] sel, input logic [3:0] res);
    chk({tag, ".busy"},   {3'b0, busy},         {3'b0, b});
    chk({tag, ".valid"},  {3'b0, result_valid}, {3'b0, v});
    chk({tag, ".sel"},    {2'b0, s1, s0},       {2'b0, sel});
    chk({tag, ".result"}, result,               res);
  endtask

  // Full 1111 scan with SETTLE_CYCLES=2. The select after edge e is e/2, and the result arrives after edge 8.
  task automatic full_scan(input string tag, input logic [3:0] exp_res);
    mask = 4'b1111; start = 1'b1; result_ready = 1'b0;
    step();
    start = 1'b0;
    chk({tag, ".e0.sel"}, {2'b0, s1, s0}, 4'd0);
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("%s.e%0d.sel", tag, e), {2'b0, s1, s0}, (e < 8) ? 4'(e / 2) : 4'd3);
      chk($sformatf("%s.e%0d.valid", tag, e), {3'b0, result_valid}, (e == 8) ? 4'd1 : 4'd0);
    end
    chk({tag, ".result"}, result, exp_res);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; mask = 4'b1111; result_ready = 1'b0; mux_in = 4'b0101;

    // Reset held for two cycles with start high.
    step(); step();
    chk_all("reset", 1'b0, 1'b0, 2'b00, 4'b0000);
    reset = 1'b0; start = 1'b0;
    step();
    chk_all("post_reset_idle", 1'b0, 1'b0, 2'b00, 4'b0000);

    // Full scan, IN0=1 IN2=1. With ready high, valid lasts exactly one cycle.
    full_scan("full", 4'b0101);
    result_ready = 1'b1;
    step();
    chk_all("full_handshake", 1'b0, 1'b0, 2'b11, 4'b0101);
    result_ready = 1'b0;

    // Partial mask 1010 with backpressure.
    mask = 4'b1010; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("part.e0", 1'b1, 1'b0, 2'b01, 4'b0000);
    step();
    chk("part.e1.sel", {2'b0, s1, s0}, 4'd1);
    step();
    chk("part.e2.sel", {2'b0, s1, s0}, 4'd3);
    step(); step();
    chk_all("part.e4", 1'b1, 1'b1, 2'b11, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("part.hold%0d.valid", i), {3'b0, result_valid}, 4'd1);
    end
    result_ready = 1'b1;
    step();
    chk_all("part.handshake", 1'b0, 1'b0, 2'b11, 4'b0000);
    result_ready = 1'b0;

    // Rerun the partial mask with IN3=1.
    mux_in = 4'b1000; mask = 4'b1010; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    chk_all("part3.e4", 1'b1, 1'b1, 2'b11, 4'b1000);
    result_ready = 1'b1;
    step();
    chk_all("part3.handshake", 1'b0, 1'b0, 2'b11, 4'b1000);
    result_ready = 1'b0;

    // An empty mask goes to DONE one edge after start, and the select is left unchanged.
    mask = 4'b0000; start = 1'b1;
    step();
    start = 1'b0;
    chk_all("empty.e0", 1'b1, 1'b1, 2'b11, 4'b0000);
    result_ready = 1'b1;
    step();
    chk_all("empty.handshake", 1'b0, 1'b0, 2'b11, 4'b0000);
    result_ready = 1'b0;

    // Starts pulsed during SETTLE and in the handshake cycle are ignored.
    mux_in = 4'b0101; mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; mask = 4'b0001;
    step();
    start = 1'b0; mask = 4'b1111;
    chk("ign.e3.sel", {2'b0, s1, s0}, 4'd1);
    step(); step(); step(); step();
    chk("ign.e7.valid", {3'b0, result_valid}, 4'd0);
    step();
    chk_all("ign.e8", 1'b1, 1'b1, 2'b11, 4'b0101);
    start = 1'b1; result_ready = 1'b1;
    step();
    start = 1'b0; result_ready = 1'b0;
    chk_all("ign.handshake", 1'b0, 1'b0, 2'b11, 4'b0101);
    step();
    chk("ign.stay_idle.busy", {3'b0, busy}, 4'd0);

    // Reset lands on the second sample edge (edge 4) of a full scan.
    mask = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all("rst_mid", 1'b0, 1'b0, 2'b00, 4'b0000);

    // Reset while in DONE, with ready held low.
    full_scan("pre_rst_done", 4'b0101);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all("rst_done", 1'b0, 1'b0, 2'b00, 4'b0000);

    // A clean scan after the resets.
    full_scan("final", 4'b0101);
    result_ready = 1'b1;
    step();
    chk_all("final_handshake", 1'b0, 1'b0, 2'b11, 4'b0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

- Drives the select lines (`s1`, `s0`) of a downstream `mux4_to_1` and samples its single-bit output channel by channel.
- On a start request it steps through the enabled inputs in ascending order and holds each select for a programmable settle time.
- It packs the sampled bits into a 4-bit result and delivers it through a valid/ready handshake.
- It replaces hand-written select stimulus as the controlling stage directly upstream of the mux.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 2: clock cycles each select value is held before the mux output is sampled. Legal range is 1 to 255.
- `CNT_W`, default 8: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- `clock`  in  1: single clock. Everything is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: scan request. Sampled only in IDLE.
- `mask`  in  4: channel enable. Bit i=1 scans input i. Latched when `start` is accepted.
- `mux_out`  in  1: the mux output (OUTPUT).
- `s1`  out  1: mux select MSB.
- `s0`  out  1: mux select LSB.
- `busy`  out  1: high in every state except IDLE.
- `result`  out  4: bit i holds the sampled `mux_out` for channel i. Masked channels read 0.
- `result_valid`  out  1: `result` is complete and stable.
- `result_ready`  in  1: consumer accepts `result`.

## Operation

States: IDLE, SETTLE, DONE.

IDLE:
- `busy`=0 and `result_valid`=0.
- `s1`/`s0` hold their last value.
- `start`=1 at an edge latches `mask`, clears `result`, and clears the settle counter.
  - If the latched mask is nonzero: `{s1,s0}` is set to the lowest enabled channel index and the state goes to SETTLE.
  - If the mask is 0000: the state goes directly to DONE with `result`=0000 and `result_valid`=1.

SETTLE:
- The counter increments once per cycle.
- On the edge where the counter reaches SETTLE_CYCLES-1, `mux_out` is written into `result[{s1,s0}]` and the counter clears.
  - If a higher enabled channel remains, `{s1,s0}` moves to it on that same edge.
  - Otherwise the state goes to DONE and `result_valid` is set on that same edge.

DONE:
- `result_valid`=1 and `busy`=1. `result` and `s1`/`s0` are frozen.
- An edge with `result_ready`=1 completes the transfer: state goes to IDLE and `result_valid` clears.

Further rules:
- `start` is ignored outside IDLE, including in the cycle the handshake completes.
- A new scan needs `start` in a later cycle.
- `mask` and `start` changes during SETTLE or DONE have no effect.
- Channels with a 0 mask bit are skipped entirely and consume no cycles.

## Timing

- Reset values (applied at the first edge with `reset`=1, from any state including mid-scan or DONE):
  - state=IDLE.
  - `s1`=0, `s0`=0.
  - `busy`=0.
  - `result`=0000.
  - `result_valid`=0.
  - Internal counter and latched mask are cleared.
- `reset` takes priority over `start` and `result_ready`. A scan in progress is abandoned with no partial result.
- Latency: let edge 0 be the edge that accepts `start`, and N the number of enabled channels.
  - Select for the first channel is visible after edge 0.
  - Channel k (k=1..N, in scan order) is sampled at edge k·SETTLE_CYCLES.
  - `result_valid` is visible after edge N·SETTLE_CYCLES.
  - With mask=0000, `result_valid` is visible after edge 0.
- Each select value is stable for exactly SETTLE_CYCLES cycles before it is sampled.
- `mux_out` is sampled at the clock edge. It must be settled within SETTLE_CYCLES cycles of the select change.
- Back-to-back throughput: the earliest new `start` is accepted one cycle after the handshake edge (IDLE for at least one cycle).
- `result_valid` never drops without a handshake or reset.

## Test plan

- **Reset:** drive `reset`=1 for 2 cycles with `start`=1 → all outputs 0 and state IDLE; no scan starts while reset is high.
- **Full scan:** mux inputs IN0=1, IN1=0, IN2=1, IN3=0; `mask`=1111; SETTLE_CYCLES=2; `result_ready`=1 → select sequence 00, 01, 10, 11 with 2 cycles each; `result`=0101; `result_valid` visible after edge 8 for exactly 1 cycle.
- **Partial mask and backpressure:** same inputs, `mask`=1010, `result_ready`=0 → only selects 01 and 11 are driven; `result`=0000 (both sampled bits are 0). Rerun with IN3=1 → `result`=1000. `result_valid` stays high until `result_ready` is raised, then drops on the next edge.
- **Empty mask:** `mask`=0000 → `result_valid`=1 and `result`=0000 one edge after `start`; selects unchanged.
- **Ignored start:** pulse `start` during SETTLE and in the handshake cycle → no restart, latency unchanged, state returns to IDLE. A later `start` runs a normal scan.
- **Reset mid-operation:** assert `reset` at the second sample of a full scan, and separately while in DONE → outputs return to reset values on that edge. A subsequent scan yields the correct `result`=0101.
